apb_rr_master_arbiter: RTL

- Shares one APB master port between N_REQ on-chip requesters.
- Each requester hands over a command (addr/write/wdata) through a valid/ready handshake. The block arbitrates round-robin, runs the APB SETUP and ACCESS phases, and returns PRDATA/PSLVERR through a one-cycle response pulse.
- A watchdog aborts transfers whose slave never asserts PREADY.
- Sits between the CPU-side/DMA-side command sources and the APB slave fabric.

---
 rtl/apb_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/apb_rr_master_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types, default widths and the round-robin helper used by the APB
// master arbiter and by any other block that shares a resource round-robin.
//   apb_state_e : APB master phase (IDLE / SETUP / ACCESS)
//   rr_next()   : next index after 'idx' in a ring of 'n' entries
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Ring increment without a modulo operator, so it stays cheap for any n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant. The search starts at the entry just
// after last_grant and wraps, so the most recent winner has lowest priority.
// Ports:
//   req         in  N_REQ          request vector
//   last_grant  in  $clog2(N_REQ)  index of the previous winner
//   grant       out N_REQ          one-hot grant, zero when no request
//   grant_idx   out $clog2(N_REQ)  binary index of the grant
//   grant_valid out 1              any request granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  int unsigned cand;

  // Walk the ring once starting after last_grant; the first requester found
  // wins and later hits are ignored.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 32'(last_grant);
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_next(cand, N_REQ);
      if (!grant_valid && req[IDX_W'(cand)]) begin
        grant_valid            = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_master_arbiter
// Shares one APB master port between N_REQ requesters. Commands are accepted
// round-robin in IDLE, run through SETUP and ACCESS, and the result comes back
// as a one-cycle rsp_valid pulse to the owner. A watchdog aborts an ACCESS
// phase that never sees PREADY and reports it as an error.
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   req_valid/req_ready          per-requester command handshake
//   req_write/req_addr/req_wdata packed per-requester command fields
//   rsp_valid/rsp_rdata/rsp_err  completion pulse, read data, error flag
//   PSEL..PWDATA                 APB request outputs
//   PRDATA/PREADY/PSLVERR        APB completion inputs
// ---------------------------------------------------------------------------
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  apb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              accept;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Ready is only offered from IDLE and is masked during reset so a command
  // presented under reset is never silently consumed.
  assign accept    = grant_valid && (state_q == ST_IDLE) && !PRESET;
  assign req_ready = accept ? grant : '0;

  // PSEL/PENABLE fall straight out of the phase, so a reset drops them at the
  // same edge that returns the state to IDLE.
  assign PSEL      = (state_q != ST_IDLE);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state logic: everything holds by default and rsp_valid defaults low,
  // which makes the response a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pwrite_d     = req_write[grant_idx];
          paddr_d      = req_addr[grant_idx*ADDR_W +: ADDR_W];
          pwdata_d     = req_wdata[grant_idx*DATA_W +: DATA_W];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wdog_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A PREADY arriving on the last watchdog cycle still completes
        // normally; only a missing PREADY turns into an abort.
        if (PREADY) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
          rsp_err_d            = PSLVERR;
          state_d              = ST_IDLE;
        end else if (wdog_q == WD_LAST) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          state_d              = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; last_grant starts at the top
  // index so requester 0 is first in line after reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= LAST_RESET;
      wdog_q       <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
